uart_rx_os: RTL

Parametrised, oversampled UART receiver; next generation of the single-sample-per-clock bit receiver.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_baud_tick.sv | 41 ++++
 rtl/uart_rx_os.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared state encoding and parity-mode constants for uart_rx_os.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ============================================================================
// Module  : uart_baud_tick
// Brief   : Free-running divisor counter producing a 1-cycle sample tick.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_baud_tick #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] clk_div,
  input  logic                 clear,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] r_cnt;
  logic [DIV_WIDTH-1:0] r_lim;
  logic [DIV_WIDTH-1:0] w_lim_nx;
  logic                 w_wrap;

  // Divisor is latched only at wrap so a mid-period change never shortens a tick.
  assign w_lim_nx = (clk_div == '0) ? DIV_WIDTH'(1) : clk_div;
  assign w_wrap   = (r_cnt >= r_lim - 1'b1);
  assign tick     = w_wrap;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_lim <= DIV_WIDTH'(1);
    end else begin
      if (w_wrap) r_lim <= w_lim_nx;
      if (clear || w_wrap) r_cnt <= '0;
      else                 r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx_os.sv
// ============================================================================
// Module  : uart_rx_os
// Brief   : Oversampled UART receiver with majority vote, parity, stop check
//           and a valid/ready holding register.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_os #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic [DIV_WIDTH-1:0] clk_div,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 busy,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err
);

  import uart_pkg::*;

  localparam int c_NW = $clog2(OVERSAMPLE);
  localparam int c_BW = $clog2(DATA_BITS + 1);
  localparam logic [c_NW-1:0] c_n_one  = c_NW'(1);
  localparam logic [c_NW-1:0] c_n_s0   = c_NW'(OVERSAMPLE / 2 - 1);
  localparam logic [c_NW-1:0] c_n_s1   = c_NW'(OVERSAMPLE / 2);
  localparam logic [c_NW-1:0] c_n_s2   = c_NW'(OVERSAMPLE / 2 + 1);
  localparam logic [c_NW-1:0] c_n_end  = c_NW'(OVERSAMPLE - 1);
  localparam logic [c_BW-1:0] c_last   = c_BW'(DATA_BITS - 1);

  state_e               r_state, w_state_nx;
  logic                 r_sync1, r_rx_s, r_rx_prev;
  logic [c_NW-1:0]      r_n;
  logic [c_BW-1:0]      r_bit;
  logic [DATA_BITS-1:0] r_shift, r_data;
  logic                 r_v0, r_v1, r_par_bad, r_stop1;
  logic                 r_valid, r_perr, r_ferr, r_oerr;
  logic                 w_tick, w_dec, w_end, w_maj, w_par_bad;
  logic                 w_start, w_shift_en, w_par_rec, w_stop1_ok, w_frame_err, w_commit;

  uart_baud_tick #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_tick (
    .clk     (clk),
    .reset   (reset),
    .clk_div (clk_div),
    .clear   (w_start),
    .tick    (w_tick)
  );

  // Third vote sample is the live synchronised line at the decision tick.
  assign w_maj     = (r_v0 & r_v1) | (r_v0 & r_rx_s) | (r_v1 & r_rx_s);
  assign w_dec     = w_tick && (r_n == c_n_s2);
  assign w_end     = w_tick && (r_n == c_n_end);
  assign w_par_bad = (PARITY == PAR_EVEN) ? ((^r_shift) != w_maj) : ((^r_shift) == w_maj);

  assign data_out    = r_data;
  assign data_valid  = r_valid;
  assign busy        = (r_state != ST_IDLE);
  assign parity_err  = r_perr;
  assign frame_err   = r_ferr;
  assign overrun_err = r_oerr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx  = r_state;
    w_start     = 1'b0;
    w_shift_en  = 1'b0;
    w_par_rec   = 1'b0;
    w_stop1_ok  = 1'b0;
    w_frame_err = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_rx_prev && !r_rx_s) begin
          w_start    = 1'b1;
          w_state_nx = ST_START;
        end
      end
      ST_START: begin
        if (w_dec && w_maj) w_state_nx = ST_IDLE;
        else if (w_end)     w_state_nx = ST_DATA;
      end
      ST_DATA: begin
        w_shift_en = w_dec;
        if (w_end && (r_bit == c_last))
          w_state_nx = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        w_par_rec = w_dec;
        if (w_end) w_state_nx = ST_STOP;
      end
      ST_STOP: begin
        // Final stop returns to IDLE at mid-bit so a back-to-back start is caught.
        if (w_dec) begin
          if (!w_maj) begin
            w_frame_err = 1'b1;
            w_state_nx  = ST_BREAK;
          end else if ((STOP_BITS == 2) && !r_stop1) begin
            w_stop1_ok = 1'b1;
          end else begin
            w_commit   = 1'b1;
            w_state_nx = ST_IDLE;
          end
        end
      end
      ST_BREAK: begin
        if (r_rx_s) w_state_nx = ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1   <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
      r_v0      <= 1'b1;
      r_v1      <= 1'b1;
      r_n       <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_par_bad <= 1'b0;
      r_stop1   <= 1'b0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_oerr    <= 1'b0;
    end else begin
      r_sync1   <= rx;
      r_rx_s    <= r_sync1;
      r_rx_prev <= r_rx_s;

      // The detecting cycle itself counts as tick 0 of the start bit.
      if (w_start)                r_n <= c_n_one;
      else if (r_state == ST_IDLE) r_n <= '0;
      else if (w_tick)            r_n <= (r_n == c_n_end) ? '0 : r_n + 1'b1;

      if (w_tick && (r_n == c_n_s0)) r_v0 <= r_rx_s;
      if (w_tick && (r_n == c_n_s1)) r_v1 <= r_rx_s;

      if (w_start) begin
        r_bit     <= '0;
        r_par_bad <= 1'b0;
        r_stop1   <= 1'b0;
      end else begin
        if ((r_state == ST_DATA) && w_end) r_bit <= r_bit + 1'b1;
        if (w_par_rec)  r_par_bad <= w_par_bad;
        if (w_stop1_ok) r_stop1   <= 1'b1;
      end

      if (w_shift_en) r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};

      r_ferr <= w_frame_err;
      r_perr <= w_commit && r_par_bad;
      r_oerr <= w_commit && !r_par_bad && r_valid && !data_ready;

      if (w_commit && !r_par_bad && (!r_valid || data_ready)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && data_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
